// File: rtl/few_shot_bias_controller.sv
// Sequences the squared-log2 accumulator to produce one few-shot class bias:
// clear, stream the class's weight rows, then write the bias at the class index.
module few_shot_bias_controller #(
    parameter  int NUM_CLASSES    = 16,
    parameter  int MAX_ROWS       = 64,
    parameter  int BIAS_BIT_WIDTH = 14,
    localparam int CLASS_W        = $clog2(NUM_CLASSES),
    localparam int ROW_W          = $clog2(MAX_ROWS)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic                             abort,
    input  logic [CLASS_W-1:0]               class_idx,
    input  logic [ROW_W:0]                   num_rows,
    input  logic                             mode_4x4,
    output logic                             busy,
    output logic                             done,
    output logic                             acc_clear,
    output logic                             acc_enable,
    output logic                             acc_4x4_mode,
    input  logic signed [BIAS_BIT_WIDTH-1:0] acc_out,
    output logic                             weight_rd_en,
    output logic [CLASS_W+ROW_W-1:0]         weight_rd_addr,
    output logic                             bias_wr_en,
    output logic [CLASS_W-1:0]               bias_wr_addr,
    output logic [BIAS_BIT_WIDTH-1:0]        bias_wr_data
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        READ,
        DRAIN,
        WRITE
    } state_t;

    localparam logic [ROW_W:0]   ROWS_MAX = (ROW_W + 1)'(MAX_ROWS);
    localparam logic [ROW_W:0]   ONE_R    = (ROW_W + 1)'(1);
    localparam logic [ROW_W-1:0] ONE_C    = ROW_W'(1);

    state_t               state_q;
    logic [ROW_W-1:0]     row_cnt_q;
    logic [CLASS_W-1:0]   class_idx_q;
    logic [ROW_W:0]       rows_q;
    logic                 mode_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 acc_clear_q;
    logic                 acc_enable_q;
    logic                 rd_en_q;
    logic                 wr_en_q;

    logic [ROW_W:0]       rows_d;
    logic                 last_row;

    assign rows_d   = (num_rows > ROWS_MAX) ? ROWS_MAX : num_rows;
    assign last_row = ({1'b0, row_cnt_q} == (rows_q - ONE_R));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            row_cnt_q    <= '0;
            class_idx_q  <= '0;
            rows_q       <= '0;
            mode_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            acc_clear_q  <= 1'b0;
            acc_enable_q <= 1'b0;
            rd_en_q      <= 1'b0;
            wr_en_q      <= 1'b0;
        end else begin
            done_q       <= 1'b0;
            acc_clear_q  <= 1'b0;
            acc_enable_q <= 1'b0;
            wr_en_q      <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q     <= CLEAR;
                        class_idx_q <= class_idx;
                        rows_q      <= rows_d;
                        mode_q      <= mode_4x4;
                        row_cnt_q   <= '0;
                        busy_q      <= 1'b1;
                        acc_clear_q <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (abort) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (rows_q == '0) begin
                        state_q <= WRITE;
                        wr_en_q <= 1'b1;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= READ;
                        rd_en_q <= 1'b1;
                    end
                end
                READ: begin
                    if (abort) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        rd_en_q <= 1'b0;
                    end else begin
                        // read data lands one cycle after the strobe
                        acc_enable_q <= rd_en_q;
                        if (last_row) begin
                            state_q <= DRAIN;
                            rd_en_q <= 1'b0;
                        end else begin
                            row_cnt_q <= row_cnt_q + ONE_C;
                        end
                    end
                end
                DRAIN: begin
                    if (abort) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= WRITE;
                        wr_en_q <= 1'b1;
                        done_q  <= 1'b1;
                    end
                end
                WRITE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    rd_en_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign acc_clear      = acc_clear_q;
    assign acc_enable     = acc_enable_q;
    assign acc_4x4_mode   = mode_q;
    assign weight_rd_en   = rd_en_q;
    assign weight_rd_addr = {class_idx_q, row_cnt_q};
    assign bias_wr_en     = wr_en_q;
    assign bias_wr_addr   = class_idx_q;
    assign bias_wr_data   = wr_en_q ? acc_out : '0;

    a_clear_single: assert property (
        @(posedge clk) disable iff (rst) acc_clear |=> !acc_clear);
    a_enable_busy: assert property (
        @(posedge clk) disable iff (rst) acc_enable |-> busy);
    a_done_write: assert property (
        @(posedge clk) done == bias_wr_en);

endmodule

// File: tb/tb_few_shot_bias_controller.sv
// Bench for few_shot_bias_controller: weight memory and accumulator stubs,
// randomized jobs checked against a direct arithmetic bias model.
module tb_few_shot_bias_controller;

    localparam int NC = 16;
    localparam int MR = 64;
    localparam int BW = 14;
    localparam int CW = 4;
    localparam int RW = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic mode_4x4 = 1'b0;
    logic [CW-1:0] class_idx = '0;
    logic [RW:0] num_rows = '0;
    logic busy, done, acc_clear, acc_enable, acc_4x4_mode;
    logic signed [BW-1:0] acc_out;
    logic weight_rd_en, bias_wr_en;
    logic [CW+RW-1:0] weight_rd_addr;
    logic [CW-1:0] bias_wr_addr;
    logic [BW-1:0] bias_wr_data;

    few_shot_bias_controller #(
        .NUM_CLASSES(NC), .MAX_ROWS(MR), .BIAS_BIT_WIDTH(BW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .class_idx(class_idx), .num_rows(num_rows), .mode_4x4(mode_4x4),
        .busy(busy), .done(done), .acc_clear(acc_clear),
        .acc_enable(acc_enable), .acc_4x4_mode(acc_4x4_mode),
        .acc_out(acc_out), .weight_rd_en(weight_rd_en),
        .weight_rd_addr(weight_rd_addr), .bias_wr_en(bias_wr_en),
        .bias_wr_addr(bias_wr_addr), .bias_wr_data(bias_wr_data)
    );

    always #5 clk = ~clk;

    // weight memory holds log2 magnitudes; each row contributes 2^(2*w)
    logic [1:0] wmem [NC*MR];
    logic [1:0] rd_data_q = '0;
    int unsigned acc_sum = 0;

    always @(posedge clk) if (weight_rd_en) rd_data_q <= wmem[weight_rd_addr];
    always @(posedge clk) begin
        if (acc_clear) acc_sum <= 0;
        else if (acc_enable) acc_sum <= acc_sum + (32'd1 << (2 * rd_data_q));
    end
    assign acc_out = BW'(-int'(acc_sum / 2));

    int total = 0;
    int bad = 0;

    function automatic logic [BW-1:0] model_bias(input int cls, input int rows);
        int s = 0;
        for (int i = 0; i < rows; i++) s += 1 << (2 * int'(wmem[cls*MR+i]));
        return BW'(-(s / 2));
    endfunction

    int obs_done, obs_en, obs_wr, obs_clr, obs_mode_bad, obs_post_bad;
    logic [CW+RW-1:0] obs_addr[$];
    logic [CW-1:0] obs_wr_addr;
    logic [BW-1:0] obs_wr_data;

    task automatic run_job(input int cls, input int nr, input bit mode,
                           input int abort_at, input int rst_at, input bit poke);
        int c;
        obs_done = -1; obs_en = 0; obs_wr = 0; obs_clr = 0;
        obs_mode_bad = 0; obs_post_bad = 0; obs_addr.delete();
        obs_wr_addr = '0; obs_wr_data = '0;
        @(negedge clk);
        class_idx = CW'(cls); num_rows = (RW+1)'(nr); mode_4x4 = mode; start = 1'b1;
        for (c = 1; c <= 200; c++) begin
            @(negedge clk);
            start = 1'b0; abort = 1'b0; rst = 1'b0;
            if (acc_enable) obs_en++;
            if (acc_clear) obs_clr++;
            if (weight_rd_en) obs_addr.push_back(weight_rd_addr);
            if (bias_wr_en) begin
                obs_wr++; obs_wr_addr = bias_wr_addr; obs_wr_data = bias_wr_data;
            end
            if (done) obs_done = c;
            if (busy && acc_4x4_mode !== mode) obs_mode_bad++;
            if ((abort_at > 0 && c == abort_at + 1) || (rst_at > 0 && c == rst_at + 1))
                if ({busy, done, acc_clear, acc_enable, weight_rd_en, bias_wr_en} !== 6'b0)
                    obs_post_bad++;
            if (rst_at > 0 && c == rst_at + 1 && (weight_rd_addr !== '0 || acc_4x4_mode !== 1'b0))
                obs_post_bad++;
            if (done || (abort_at > 0 && c > abort_at + 2) || (rst_at > 0 && c > rst_at + 2))
                break;
            if (poke && (abort_at < 0 || c < abort_at) && (rst_at < 0 || c < rst_at)) begin
                start = 1'($urandom); class_idx = CW'($urandom);
                num_rows = (RW+1)'($urandom); mode_4x4 = 1'($urandom);
            end
            if (c == abort_at) abort = 1'b1;
            if (c == rst_at) rst = 1'b1;
        end
        start = 1'b0; abort = 1'b0; rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({busy, done, acc_clear, acc_enable, weight_rd_en, bias_wr_en} !== 6'b0) begin
            bad++; $display("FAIL reset_strobes got=%b want=000000",
                {busy, done, acc_clear, acc_enable, weight_rd_en, bias_wr_en});
        end
        total++;
        if (weight_rd_addr !== '0 || acc_4x4_mode !== 1'b0) begin
            bad++; $display("FAIL reset_addr_mode addr=%0d mode=%b want 0/0",
                weight_rd_addr, acc_4x4_mode);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int nb = 0;
        for (int i = 0; i < 4; i++) wmem[3*MR+i] = 2'(i);
        run_job(3, 4, 1'b0, -1, -1, 1'b0);
        total++;
        if (obs_done !== 7) begin bad++; $display("FAIL basic_done got=%0d want=7", obs_done); end
        total++;
        if (obs_en !== 4 || obs_clr !== 1) begin
            bad++; $display("FAIL basic_en_clr en=%0d clr=%0d want 4/1", obs_en, obs_clr);
        end
        total++;
        if (obs_addr.size() != 4) nb++;
        else for (int i = 0; i < 4; i++) if (obs_addr[i] !== 10'(192 + i)) nb++;
        if (nb != 0) begin bad++; $display("FAIL basic_addrs n=%0d errs=%0d", obs_addr.size(), nb); end
        total++;
        if (obs_wr !== 1 || obs_wr_addr !== 4'd3) begin
            bad++; $display("FAIL basic_wr cnt=%0d addr=%0d want 1/3", obs_wr, obs_wr_addr);
        end
        total++;
        if (obs_wr_data !== model_bias(3, 4) || obs_wr_data !== 14'h3fd6) begin
            bad++; $display("FAIL basic_data got=%h want=%h", obs_wr_data, model_bias(3, 4));
        end
    endtask

    task automatic test_zero_rows();
        run_job(5, 0, 1'b0, -1, -1, 1'b0);
        total++;
        if (obs_done !== 2 || obs_addr.size() != 0 || obs_en !== 0) begin
            bad++; $display("FAIL zero_rows done=%0d reads=%0d en=%0d want 2/0/0",
                obs_done, obs_addr.size(), obs_en);
        end
        total++;
        if (obs_wr_addr !== 4'd5 || obs_wr_data !== '0) begin
            bad++; $display("FAIL zero_data addr=%0d data=%h want 5/0", obs_wr_addr, obs_wr_data);
        end
    endtask

    task automatic test_clamp();
        run_job(9, 100, 1'b0, -1, -1, 1'b0);
        total++;
        if (obs_done !== 67 || obs_en !== 64 || obs_addr.size() != 64) begin
            bad++; $display("FAIL clamp_count done=%0d en=%0d reads=%0d want 67/64/64",
                obs_done, obs_en, obs_addr.size());
        end
        total++;
        if (obs_addr.size() == 0 || obs_addr[$] !== 10'(9*MR + 63)) begin
            bad++; $display("FAIL clamp_last_addr got=%0d want=%0d",
                (obs_addr.size() == 0) ? -1 : int'(obs_addr[$]), 9*MR + 63);
        end
        total++;
        if (obs_wr_data !== model_bias(9, 64)) begin
            bad++; $display("FAIL clamp_data got=%h want=%h", obs_wr_data, model_bias(9, 64));
        end
    endtask

    task automatic test_abort();
        run_job(6, 8, 1'b0, 4, -1, 1'b0);
        total++;
        if (obs_done !== -1 || obs_wr !== 0 || obs_post_bad !== 0 || obs_addr.size() != 3) begin
            bad++; $display("FAIL abort done=%0d wr=%0d post=%0d reads=%0d want -1/0/0/3",
                obs_done, obs_wr, obs_post_bad, obs_addr.size());
        end
        run_job(6, 8, 1'b0, -1, -1, 1'b0);
        total++;
        if (obs_done !== 11 || obs_clr !== 1 || obs_en !== 8 ||
            obs_wr_data !== model_bias(6, 8)) begin
            bad++; $display("FAIL abort_rerun done=%0d clr=%0d en=%0d data=%h want 11/1/8/%h",
                obs_done, obs_clr, obs_en, obs_wr_data, model_bias(6, 8));
        end
    endtask

    task automatic test_back_to_back();
        int nb = 0;
        run_job(2, 10, 1'b0, -1, -1, 1'b1);
        total++;
        if (obs_addr.size() != 10) nb++;
        else for (int i = 0; i < 10; i++) if (obs_addr[i] !== 10'(2*MR + i)) nb++;
        if (obs_done !== 13 || obs_wr_data !== model_bias(2, 10) || nb != 0) begin
            bad++; $display("FAIL b2b_ignore done=%0d data=%h errs=%0d want 13/%h/0",
                obs_done, obs_wr_data, nb, model_bias(2, 10));
        end
        run_job(7, 20, 1'b0, -1, 5, 1'b1);
        total++;
        if (obs_post_bad !== 0 || obs_wr !== 0 || obs_done !== -1) begin
            bad++; $display("FAIL b2b_reset post=%0d wr=%0d done=%0d want 0/0/-1",
                obs_post_bad, obs_wr, obs_done);
        end
        run_job(4, 5, 1'b0, -1, -1, 1'b0);
        total++;
        if (obs_done !== 8 || obs_wr_addr !== 4'd4 || obs_wr_data !== model_bias(4, 5)) begin
            bad++; $display("FAIL b2b_after_rst done=%0d addr=%0d data=%h want 8/4/%h",
                obs_done, obs_wr_addr, obs_wr_data, model_bias(4, 5));
        end
    endtask

    task automatic test_mode();
        run_job(1, 6, 1'b1, -1, -1, 1'b1);
        @(negedge clk);
        total++;
        if (obs_mode_bad !== 0 || acc_4x4_mode !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL mode_hold bad=%0d mode=%b busy=%b want 0/1/0",
                obs_mode_bad, acc_4x4_mode, busy);
        end
        run_job(1, 3, 1'b0, -1, -1, 1'b0);
        total++;
        if (obs_mode_bad !== 0 || obs_done !== 6) begin
            bad++; $display("FAIL mode_relatch bad=%0d done=%0d want 0/6", obs_mode_bad, obs_done);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 10; k++) begin
            int cls = int'($urandom_range(0, NC - 1));
            int nr = int'($urandom_range(0, 80));
            int rows = (nr > MR) ? MR : nr;
            int want = (rows == 0) ? 2 : 3 + rows;
            int nb = 0;
            run_job(cls, nr, 1'($urandom), -1, -1, 1'($urandom));
            if (obs_addr.size() != rows) nb++;
            else for (int i = 0; i < rows; i++) if (obs_addr[i] !== 10'(cls*MR + i)) nb++;
            total++;
            if (obs_done !== want || obs_en !== rows || nb != 0 || obs_mode_bad !== 0 ||
                obs_wr_addr !== 4'(cls) || obs_wr_data !== model_bias(cls, rows)) begin
                bad++; $display("FAIL random[%0d] cls=%0d nr=%0d done=%0d/%0d en=%0d errs=%0d data=%h/%h",
                    k, cls, nr, obs_done, want, obs_en, nb, obs_wr_data, model_bias(cls, rows));
            end
        end
    endtask

    initial begin
        for (int i = 0; i < NC*MR; i++) wmem[i] = 2'($urandom);
        test_reset();
        test_basic();
        test_zero_rows();
        test_clamp();
        test_abort();
        test_back_to_back();
        test_mode();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/few_shot_bias_controller.md
Name: few_shot_bias_controller

Overview:
Sequences the squared-log2 sum accumulator to compute one few-shot class bias (negative half squared norm of the class prototype).
- On `start`, clears the accumulator.
- Streams the class's weight rows from weight memory (1-cycle read latency) into the accumulator, one `acc_enable` per row.
- Writes the accumulator's combinational bias output into the bias memory at the class index.
- Sits between the few-shot learning control FSM, weight memory, the accumulator and bias memory.

Parameters:
- NUM_CLASSES, 16, number of bias entries; CLASS_W = $clog2(NUM_CLASSES).
- MAX_ROWS, 64, max weight rows per class, power of two; ROW_W = $clog2(MAX_ROWS).
- BIAS_BIT_WIDTH, 14, width of accumulator output and bias-memory data.

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  synchronous active-high reset.
- start  in  1  single-cycle request; sampled only in IDLE.
- abort  in  1  cancel in-flight job; no bias write occurs.
- class_idx  in  CLASS_W  class to process; latched on accepted start.
- num_rows  in  ROW_W+1  rows to accumulate; latched on accepted start; values > MAX_ROWS are clamped to MAX_ROWS.
- mode_4x4  in  1  latched on accepted start.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse, coincident with the bias write.
- acc_clear  out  1  drives accumulator rst.
- acc_enable  out  1  drives accumulator enable.
- acc_4x4_mode  out  1  latched mode_4x4; stable for the whole job.
- acc_out  in  BIAS_BIT_WIDTH  signed bias from accumulator (combinational from its register).
- weight_rd_en  out  1  weight memory read strobe.
- weight_rd_addr  out  CLASS_W+ROW_W  {class_idx_q, row_cnt}.
- bias_wr_en  out  1  bias memory write strobe.
- bias_wr_addr  out  CLASS_W  class_idx_q.
- bias_wr_data  out  BIAS_BIT_WIDTH  acc_out, passed through during WRITE.

Behaviour:
- Reset: state=IDLE; row_cnt=0; class_idx_q=0; rows_q=0; acc_4x4_mode=0.
- Reset: busy, done, acc_clear, acc_enable, weight_rd_en, bias_wr_en all 0; weight_rd_addr=0.
- Reset asserted mid-job returns to IDLE the next edge with no write.
- States:
  - IDLE: start=1 latches class_idx/num_rows/mode_4x4 and goes to CLEAR.
  - CLEAR: acc_clear=1 for exactly 1 cycle, row_cnt=0. Next state is READ, or WRITE if rows_q==0.
  - READ: weight_rd_en=1, addr={class_idx_q,row_cnt}, row_cnt++ each cycle. When row_cnt==rows_q-1, go to DRAIN.
  - DRAIN: weight_rd_en=0; 1 cycle covering the last data beat; go to WRITE.
  - WRITE: bias_wr_en=1, done=1 for 1 cycle; go to IDLE.
- acc_enable is a register equal to weight_rd_en delayed 1 cycle, so it aligns with read data. It is forced 0 in CLEAR, WRITE and IDLE.
- Latency from start to done: 3 + rows_q cycles (rows_q=0 gives 2). Exactly rows_q acc_enable pulses per job.
- bias_wr_data is sampled in WRITE, after the final accumulate edge.
- abort in CLEAR/READ/DRAIN: next state IDLE, outputs deasserted next cycle, no write, no done. abort in WRITE or IDLE is ignored.
- start while busy is ignored (not queued). start and abort together in IDLE: start wins.
- Inputs class_idx, num_rows and mode_4x4 may change freely after acceptance; only the latched copies are used.
- row_cnt never exceeds MAX_ROWS-1; no address wrap into the next class.

Test Plan:
- start with class_idx=3, num_rows=4, weight memory holding log2 values giving per-row sums 1, 4, 16, 64:
  - 4 acc_enable pulses, reads at addrs 192..195.
  - done at cycle 7 after start.
  - bias_wr_addr=3, bias_wr_data equals the accumulator model output.
- num_rows=0, class_idx=5: CLEAR then WRITE, done 2 cycles after start, 0 read strobes, bias_wr_data=0.
- num_rows=100 with MAX_ROWS=64: clamped to 64 reads, last addr {class,63}, done 67 cycles after start.
- abort during the 3rd READ cycle: busy drops next cycle, no bias_wr_en, no done; a following start runs a clean full job from CLEAR.
- start pulsed repeatedly while busy, plus rst asserted mid-READ: extra starts ignored; after rst all outputs 0 and the next start behaves normally.
- mode_4x4=1 at start, then toggled during the job: acc_4x4_mode stays 1 until the next accepted start.
